// File: rtl/compactor_misr_pkg.sv
// Shared types and defaults for the compactor MISR checker.
// The compactor width constant lets the checker reject a mismatched MISR width at elaboration.
package compactor_misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam int         COMP_W   = 6;
    localparam logic [5:0] DEF_POLY = 6'b000010;
    localparam logic [5:0] DEF_SEED = 6'b000000;

endpackage

// File: rtl/compactor_misr_checker_misr_reg.sv
// Multiple-input signature register: load forces SEED, en folds one word in.
// Updates on the clock edge; load takes priority over en.
module misr_reg #(
    parameter int           W    = 6,
    parameter logic [W-1:0] POLY = 6'b000010,
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] fb;

    always_comb begin
        // Stage 0 always takes the top bit, regardless of POLY[0].
        fb  = {W{q_q[W-1]}} & {POLY[W-1:1], 1'b1};
        q_d = q_q;
        if (load) begin
            q_d = SEED;
        end else if (en) begin
            q_d = {q_q[W-2:0], 1'b0} ^ fb ^ d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/compactor_misr_checker.sv
// Accumulates num_vec compacted words into a MISR, then compares against golden.
// Verdict registers one cycle after the last vector; in_valid has no backpressure.
module compactor_misr_checker
    import compactor_misr_pkg::*;
#(
    parameter int           W    = COMP_W,
    parameter int           CW   = 16,
    parameter logic [W-1:0] POLY = DEF_POLY,
    parameter logic [W-1:0] SEED = DEF_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_vec,
    input  logic          in_valid,
    input  logic [W-1:0]  com_res,
    input  logic [W-1:0]  golden,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [W-1:0]  signature,
    output logic [CW-1:0] vec_cnt
);

    if (W != COMP_W) begin : g_bad_width
        $error("compactor_misr_checker: W must match the compactor output width");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] num_q, num_d;
    logic [CW-1:0] cnt_inc;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          done_q, done_d;
    logic          misr_load;
    logic          misr_en;

    assign cnt_inc = cnt_q + {{(CW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        done_d    = 1'b0;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    num_d     = num_vec;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    state_d   = (num_vec == '0) ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    misr_en = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                pass_d  = (signature == golden);
                fail_d  = (signature != golden);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
        end
    end

    misr_reg #(
        .W    (W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (misr_load),
        .en    (misr_en),
        .d     (com_res),
        .q     (signature)
    );

    assign busy    = (state_q == ST_RUN) || (state_q == ST_CHECK);
    assign done    = done_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign vec_cnt = cnt_q;

endmodule

// File: tb/tb_compactor_misr_checker.sv
// Directed bench: stimulus pushes expected verdicts, a negedge monitor checks each done pulse.
module tb_compactor_misr_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic        in_valid;
    logic [5:0]  com_res;
    logic [5:0]  golden;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [5:0]  signature;
    logic [15:0] vec_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic        pass;
        logic        fail;
        logic [5:0]  sig;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    compactor_misr_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .in_valid  (in_valid),
        .com_res   (com_res),
        .golden    (golden),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .signature (signature),
        .vec_cnt   (vec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued verdict.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no verdict (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("verdict_pass", {31'b0, pass}, {31'b0, mon_e.pass});
                chk("verdict_fail", {31'b0, fail}, {31'b0, mon_e.fail});
                chk("verdict_sig", {26'b0, signature}, {26'b0, mon_e.sig});
                chk("verdict_cnt", {16'b0, vec_cnt}, {16'b0, mon_e.cnt});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        step();
        start   = 1'b0;
        num_vec = 16'hdead;
    endtask

    task automatic send(input logic [5:0] d);
        in_valid = 1'b1;
        com_res  = d;
        step();
        in_valid = 1'b0;
        com_res  = 6'h2a;
    endtask

    task automatic expect_verdict(input logic p, input logic [5:0] s, input logic [15:0] c);
        exp_t e;
        e.pass = p;
        e.fail = ~p;
        e.sig  = s;
        e.cnt  = c;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        num_vec  = '0;
        in_valid = 1'b0;
        com_res  = '0;
        golden   = '0;
        step();
        step();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_pass", {31'b0, pass}, 0);
        chk("rst_fail", {31'b0, fail}, 0);
        chk("rst_sig", {26'b0, signature}, 0);
        chk("rst_cnt", {16'b0, vec_cnt}, 0);
        rst_n = 1'b1;
        step();

        // Session A: two vectors, matching golden.
        golden = 6'b000011;
        do_start(16'd2);
        chk("a_busy", {31'b0, busy}, 1);
        send(6'b000001);
        chk("a_sig1", {26'b0, signature}, 6'b000001);
        chk("a_cnt1", {16'b0, vec_cnt}, 1);
        send(6'b000001);
        expect_verdict(1'b1, 6'b000011, 16'd2);
        chk("a_sig2", {26'b0, signature}, 6'b000011);
        wait_drain("a_timeout");

        // Session B: same vectors, wrong golden, verdict held while idle.
        golden = 6'b000010;
        do_start(16'd2);
        chk("b_pass_cleared", {31'b0, pass}, 0);
        send(6'b000001);
        send(6'b000001);
        expect_verdict(1'b0, 6'b000011, 16'd2);
        wait_drain("b_timeout");
        for (int i = 0; i < 10; i++) step();
        chk("b_hold_fail", {31'b0, fail}, 1);
        chk("b_hold_pass", {31'b0, pass}, 0);
        chk("b_hold_busy", {31'b0, busy}, 0);

        // Session C: gaps between vectors hold all state.
        golden = 6'b000011;
        do_start(16'd2);
        send(6'b100000);
        chk("c_sig1", {26'b0, signature}, 6'b100000);
        for (int i = 0; i < 3; i++) begin
            com_res = 6'h3f;
            step();
            chk("c_gap_sig", {26'b0, signature}, 6'b100000);
            chk("c_gap_cnt", {16'b0, vec_cnt}, 1);
            chk("c_gap_busy", {31'b0, busy}, 1);
        end
        send(6'b000000);
        expect_verdict(1'b1, 6'b000011, 16'd2);
        wait_drain("c_timeout");

        // Session D: num_vec=0 goes straight to CHECK with the seed.
        golden = 6'b000000;
        do_start(16'd0);
        expect_verdict(1'b1, 6'b000000, 16'd0);
        chk("d_sig_seed", {26'b0, signature}, 0);
        wait_drain("d_timeout");

        // Session E: start pulsed during RUN is ignored.
        golden = 6'b000111;
        do_start(16'd3);
        send(6'b000001);
        send(6'b000001);
        do_start(16'd0);
        chk("e_cnt_after_start", {16'b0, vec_cnt}, 2);
        chk("e_busy_after_start", {31'b0, busy}, 1);
        chk("e_sig_after_start", {26'b0, signature}, 6'b000011);
        send(6'b000001);
        expect_verdict(1'b1, 6'b000111, 16'd3);
        wait_drain("e_timeout");

        // Session F: reset mid-session discards everything.
        golden = 6'b000000;
        do_start(16'd4);
        send(6'b000101);
        send(6'b010001);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("f_busy", {31'b0, busy}, 0);
        chk("f_done", {31'b0, done}, 0);
        chk("f_pass", {31'b0, pass}, 0);
        chk("f_fail", {31'b0, fail}, 0);
        chk("f_sig", {26'b0, signature}, 0);
        chk("f_cnt", {16'b0, vec_cnt}, 0);
        for (int i = 0; i < 3; i++) send(6'b111111);
        chk("f_idle_sig", {26'b0, signature}, 0);
        chk("f_idle_cnt", {16'b0, vec_cnt}, 0);
        chk("f_idle_busy", {31'b0, busy}, 0);

        // Session G: start coincident with done is accepted.
        golden = 6'b000001;
        do_start(16'd1);
        send(6'b000001);
        expect_verdict(1'b1, 6'b000001, 16'd1);
        step();
        chk("g_done_high", {31'b0, done}, 1);
        golden = 6'b000010;
        do_start(16'd1);
        chk("g_done_dropped", {31'b0, done}, 0);
        chk("g_pass_cleared", {31'b0, pass}, 0);
        chk("g_fail_cleared", {31'b0, fail}, 0);
        chk("g_busy", {31'b0, busy}, 1);
        chk("g_sig_seed", {26'b0, signature}, 0);
        send(6'b000010);
        expect_verdict(1'b1, 6'b000010, 16'd1);
        wait_drain("g_timeout");

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compactor_misr_checker.md
Name: compactor_misr_checker

Overview:
- Sits directly downstream of the 16-bit adder's 6-bit XOR space compactor.
- Folds one compacted response word per test vector into a multiple-input signature register (MISR).
- After a programmed number of vectors, compares the final signature against a golden value and reports pass/fail.
- Turns the compactor's per-vector output into a single end-of-test verdict for the ripple-adder DFT flow.

Parameters:
- W, 6, compacted response / MISR width; must equal the compactor output width.
- CW, 16, vector-count width.
- POLY, 6'b000010, feedback tap mask. Bit i set means m[W-1] feeds stage i (x^6+x+1). Bit 0 is ignored; stage 0 always takes m[W-1].
- SEED, 6'b000000, MISR value loaded at start and on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request to begin a session; honoured only in IDLE.
- num_vec  in  CW  number of vectors to accumulate; sampled when start is accepted.
- in_valid  in  1  com_res carries a valid word this cycle.
- com_res  in  W  compacted response from the compactor.
- golden  in  W  expected signature; sampled in the CHECK cycle.
- busy  out  1  high in RUN and CHECK.
- done  out  1  one-cycle pulse when the verdict is registered.
- pass  out  1  verdict: signature == golden; held until the next accepted start.
- fail  out  1  verdict: signature != golden; held until the next accepted start.
- signature  out  W  current MISR contents.
- vec_cnt  out  CW  vectors accepted in the current session.

Behaviour:
- Reset is synchronous (rst_n low at a clock edge) and also applies mid-session:
  - state=IDLE, signature=SEED, vec_cnt=0.
  - busy=0, done=0, pass=0, fail=0.
  - Any in-progress session is discarded.
- MISR update, on an accepted vector d (m = current value):
  - m'[0] = m[W-1] ^ d[0]
  - m'[i] = m[i-1] ^ d[i] ^ (POLY[i] & m[W-1]) for i = 1..W-1
- FSM states: IDLE, RUN, CHECK.
- IDLE:
  - in_valid is ignored.
  - On start: signature<=SEED, vec_cnt<=0, latch num_vec, clear pass/fail.
  - Next state is RUN, or CHECK if num_vec==0.
- RUN:
  - Each cycle with in_valid=1: MISR updates and vec_cnt increments.
  - Cycles with in_valid=0 hold all state; gaps are unlimited.
  - When the accepted vector makes vec_cnt equal the latched num_vec, next state is CHECK.
  - start is ignored throughout RUN.
- CHECK (exactly one cycle):
  - Compare signature with golden.
  - At the closing edge: pass/fail registered, done=1 for the following cycle, state<=IDLE.
  - in_valid is ignored in CHECK.
- Latency:
  - Last vector accepted at edge t; CHECK occupies the cycle after t.
  - done, pass and fail are visible after edge t+1.
  - With num_vec=0: start accepted at edge s; done is visible after edge s+1 and signature=SEED.
- Exactly one of pass/fail is high after the first completed session. Both stay 0 after reset until then.
- start coincident with done (state is IDLE): accepted; pass/fail clear at that edge and done drops.
- vec_cnt does not wrap: the session ends at num_vec ≤ 2^CW-1.
- X on com_res while in_valid=1 is the caller's fault; no X-masking is provided.

Decomposition:
- Package compactor_misr_pkg holds:
  - the state enum (IDLE/RUN/CHECK);
  - the default POLY and SEED constants;
  - a localparam for the compactor output width (6), so W can be checked against it.
- One sub-module, misr_reg:
  - ports clk, rst_n, load, en, d, q; parameters W, POLY, SEED;
  - pure register plus feedback network.
- The checker owns the FSM, counter and compare logic.

Test Plan:
- Reset, then start with num_vec=2; vectors 6'b000001, 6'b000001 with in_valid=1, golden=6'b000011 -> signature 000001 then 000011; done pulse; pass=1, fail=0, vec_cnt=2.
- Same vectors with golden=6'b000010 -> done pulse, fail=1, pass=0. Verdict held for 10 idle cycles.
- num_vec=2, vectors 6'b100000, 6'b000000, with 3 in_valid=0 gap cycles between them, golden=6'b000011 -> gaps hold state; signature 100000 then 000011; pass=1.
- start with num_vec=0, golden=6'b000000 -> done visible after edge s+1, signature=000000, pass=1. A second start pulsed during RUN of a later session -> ignored, vec_cnt unaffected.
- num_vec=4, rst_n low for one cycle after 2 vectors -> state IDLE, signature=SEED, busy/done/pass/fail=0. Further in_valid pulses are ignored until the next start.
- start asserted in the same cycle done is high -> new session accepted, pass/fail cleared, busy=1 next cycle.
